// File: rtl/uart_out.sv
// UART transmitter: idle-high 8N1 frame on srl_out, fed by a send/ready handshake.
// Define UART_OUT_PARITY_EN to insert an even parity bit between data and stop (8E1).
module uart_out #(
   parameter int unsigned DIV_SIZE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       send,
   output logic       ready,
   output logic       srl_out,
   output logic       byte_done
);

`ifdef UART_OUT_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4,
      DONE  = 3'd5
   } state_t;
`endif

   localparam logic [31:0] LAST_TICK = 32'(DIV_SIZE - 1);

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        srl_q, srl_d;
   logic        bit_end;
   logic        accept;
`ifdef UART_OUT_PARITY_EN
   logic        parity_q, parity_d;
`endif

   assign bit_end = (timer_q == LAST_TICK);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 32'd1;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      accept    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            timer_d = 32'd0;
            state_d = IDLE;
            if (send) begin
               accept    = 1'b1;
               state_d   = START;
               shreg_d   = data_in;
               bit_cnt_d = 4'd0;
            end
         end
         START: begin
            if (bit_end) begin
               timer_d = 32'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               timer_d   = 32'd0;
               shreg_d   = {1'b0, shreg_q[7:1]};
               bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd8 : bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
`ifdef UART_OUT_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_OUT_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               timer_d = 32'd0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               timer_d = 32'd0;
               state_d = DONE;
            end
         end
         default: begin
            state_d   = IDLE;
            timer_d   = 32'd0;
            bit_cnt_d = 4'd0;
         end
      endcase
   end

`ifdef UART_OUT_PARITY_EN
   assign parity_d = accept ? ^data_in : parity_q;
`endif

   // Line level is decoded from the next state so the registered output lines up with it.
   always_comb begin
      srl_d = 1'b1;
      case (state_d)
         START:  srl_d = 1'b0;
         DATA:   srl_d = shreg_d[0];
`ifdef UART_OUT_PARITY_EN
         PARITY: srl_d = parity_d;
`endif
         default: srl_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= 32'd0;
         bit_cnt_q <= 4'd0;
         shreg_q   <= 8'd0;
         srl_q     <= 1'b1;
`ifdef UART_OUT_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         srl_q     <= srl_d;
`ifdef UART_OUT_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign srl_out   = srl_q;
   assign ready     = (state_q == IDLE) || (state_q == DONE);
   assign byte_done = (state_q == DONE);

endmodule
